pc_sequencer: RTL
=================

# pc_sequencer

Program-counter sequencer for the lab CPU datapath, directly downstream of the conditional-branch evaluator. It consumes the single-bit branch decision together with the resolving instruction's PC and signed offset, and computes the next fetch address. It issues a one-cycle flush and a one-cycle fetch bubble on every taken branch, and handles stall and halt. A saturating taken-branch counter is kept for debug.

## Interface
- N, 32, PC / address width (word-addressed instruction memory)
- IMM_W, 16, branch offset width (signed)
- RESET_PC, 0, PC value loaded on reset

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- resolve  in  1  an instruction carrying a branch condition is resolving this cycle
- branch  in  1  branch decision from the condition evaluator; meaningful only when resolve=1
- br_pc  in  N  PC of the resolving instruction
- br_imm  in  IMM_W  signed PC-relative offset of the resolving instruction
- stall  in  1  hold the current PC (downstream not ready)
- halt_req  in  1  halt instruction decoded
- pc  out  N  current fetch address
- fetch_valid  out  1  pc is a valid fetch this cycle
- flush  out  1  one-cycle pulse that squashes all younger in-flight instructions
- halted  out  1  sequencer is in HALT
- taken_cnt  out  16  saturating count of taken branches

## Operation
- States: RUN, BUBBLE, HALT. Outputs are Moore-decoded from registered state, except pc/flush/taken_cnt, which are registers.
  - fetch_valid = (state==RUN)
  - halted = (state==HALT)
- Branch target = br_pc + sign_extend(br_imm) to N bits, truncated modulo 2^N. The sequential next PC is pc + 1, also modulo 2^N. 0xFFFF_FFFF wraps to 0.
- RUN, priority highest first:
  1. resolve & branch: pc<=target, flush<=1, taken_cnt += 1 (saturating), state->BUBBLE. This applies regardless of stall or halt_req, because the younger halt is squashed.
  2. halt_req: pc holds, state->HALT.
  3. stall: pc holds, state stays RUN.
  4. Otherwise: pc<=pc+1.
- resolve & ~branch has no effect beyond the normal priority chain (not-taken).
- BUBBLE:
  - Lasts exactly one cycle, then state->RUN, independent of stall.
  - resolve, branch, and halt_req are ignored, since the pipeline is flushed.
  - pc holds the target and flush<=0.
- HALT:
  - pc, taken_cnt, and flush=0 are frozen.
  - All inputs are ignored. Only rst=0 exits.
- taken_cnt saturates at 0xFFFF and never wraps.
- Reset (rst=0 at a rising edge), from any state including mid-BUBBLE:
  - pc=RESET_PC, state=RUN, flush=0, taken_cnt=0.
  - This gives fetch_valid=1 and halted=0 on the first cycle after release.

## Timing
- Branch latency: taken resolve sampled at edge k. After edge k: pc=target and flush=1, with fetch_valid=0 for that cycle. After edge k+1: flush=0, fetch_valid=1, and the fetch at target is valid. pc increments to target+1 at edge k+2 if not stalled.
- flush is high for exactly one cycle per taken branch. It is never asserted back-to-back, because BUBBLE blocks resolve.
- halt_req sampled at edge k gives halted=1 and fetch_valid=0 after edge k. pc equals the value it held at edge k.
- stall has zero-cycle effect: pc does not change at any edge where stall=1 in RUN, unless a taken branch occurs.
- No combinational path from inputs to outputs.

## Test plan
- Reset and increment: hold rst=0 for 2 cycles with RESET_PC=0x10, then release with no other inputs.
  - Required: pc=0x10, 0x11, 0x12 on successive cycles.
  - Required: fetch_valid=1, flush=0, taken_cnt=0.
- Taken and not-taken:
  - At pc=0x20, drive resolve=1, branch=1, br_pc=0x1E, br_imm=-4 (0xFFFC). Required: next cycle pc=0x1A, flush=1, fetch_valid=0. Cycle after: fetch_valid=1, pc=0x1A. Then 0x1B. taken_cnt=1.
  - Repeat with branch=0. Required: pc=0x21, no flush.
- Priority: at the same edge, drive resolve=1, branch=1, stall=1, halt_req=1 with target 0x40.
  - Required: pc=0x40, flush=1, BUBBLE, then RUN. halted stays 0.
  - Also: a resolve driven during BUBBLE is ignored.
- Halt: stall for 3 cycles at pc=0x30, then halt_req=1.
  - Required: pc stays 0x30, halted=1, fetch_valid=0. A later taken resolve is ignored.
  - Required: rst=0 for 1 cycle returns pc=RESET_PC, halted=0.
- Wrap: pc=0xFFFF_FFFF increments to 0x0000_0000. br_pc=0xFFFF_FFF0 with br_imm=0x0020 gives target 0x0000_0010.
- Saturation and reset-mid-branch:
  - 65,537 taken branches leave taken_cnt=0xFFFF.
  - Asserting rst=0 during BUBBLE gives pc=RESET_PC, flush=0, taken_cnt=0, state RUN.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next fetch address, taken-branch flush/bubble,
// stall and halt handling, plus a saturating taken-branch counter for debug.
module pc_sequencer #(
   parameter int          N        = 32,
   parameter int          IMM_W    = 16,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    resolve,
   input  logic                    branch,
   input  logic [N-1:0]            br_pc,
   input  logic signed [IMM_W-1:0] br_imm,
   input  logic                    stall,
   input  logic                    halt_req,
   output logic [N-1:0]            pc,
   output logic                    fetch_valid,
   output logic                    flush,
   output logic                    halted,
   output logic [15:0]             taken_cnt
);

   typedef enum logic [1:0] {RUN, BUBBLE, HALT} state_t;

   state_t        state, state_nxt;
   logic [N-1:0]  pc_nxt;
   logic          flush_nxt;
   logic [15:0]   taken_cnt_nxt;

   // Target wraps modulo 2^N; the offset is sign-extended before the add.
   function automatic logic [N-1:0] branch_target(input logic [N-1:0]            base,
                                                   input logic signed [IMM_W-1:0] off);
      logic signed [N-1:0] off_ext;
      off_ext = {{(N-IMM_W){off[IMM_W-1]}}, off};
      return base + off_ext;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= RUN;
         pc        <= RESET_PC;
         flush     <= 1'b0;
         taken_cnt <= 16'd0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         flush     <= flush_nxt;
         taken_cnt <= taken_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      flush_nxt     = 1'b0;
      taken_cnt_nxt = taken_cnt;
      case (state)
         RUN: begin
            // A taken branch outranks halt_req and stall: the younger halt is squashed.
            if (resolve && branch) begin
               pc_nxt        = branch_target(br_pc, br_imm);
               flush_nxt     = 1'b1;
               taken_cnt_nxt = sat_inc(taken_cnt);
               state_nxt     = BUBBLE;
            end else if (halt_req) begin
               state_nxt = HALT;
            end else if (!stall) begin
               pc_nxt = pc + N'(1);
            end
         end
         BUBBLE:  state_nxt = RUN;
         HALT:    state_nxt = HALT;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      fetch_valid = (state == RUN);
      halted      = (state == HALT);
   end

endmodule
